// File: rtl/riscv_m_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 op codes,
// FSM state encoding and small decode helpers.
package riscv_m_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return f3[2] & f3[1];
    endfunction

    // rs1 is unsigned only for MULHU/DIVU/REMU; rs2 additionally unsigned for MULHSU
    function automatic logic is_signed_a(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f3);
        return is_signed_a(f3) && (f3 != F3_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Two's-complement conditional negate; gives |x| when neg_i is the sign bit,
// or applies the final result sign.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring
// divide over WIDTH cycles, sharing one 2*WIDTH accumulator.
module alu_muldiv_unit
    import riscv_m_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [1:0]       dbg_state_o
);

    // Handshake: Start is taken on an edge where the unit is IDLE or DONE and
    // Flush is low; Busy is high while iterating; Done pulses with Result valid,
    // and a Start seen during that Done cycle issues the next op back-to-back.

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic [2:0]         f3_q, f3_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_by_zero, div_ovf, special;
    logic [WIDTH-1:0] special_res;
    logic             new_neg;

    assign sign_a = is_signed_a(funct3) & SrcA[WIDTH-1];
    assign sign_b = is_signed_b(funct3) & SrcB[WIDTH-1];

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i (SrcA),
        .neg_i (sign_a),
        .res_o (mag_a)
    );

    muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i (SrcB),
        .neg_i (sign_b),
        .res_o (mag_b)
    );

    assign div_by_zero = is_div(funct3) && (SrcB == {WIDTH{1'b0}});
    assign div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                         (SrcA == MIN_INT) && (SrcB == ALL_ONES);
    assign special     = div_by_zero | div_ovf;

    always_comb begin
        special_res = {WIDTH{1'b0}};
        if (div_by_zero)
            special_res = is_rem(funct3) ? SrcA : ALL_ONES;
        else
            special_res = is_rem(funct3) ? {WIDTH{1'b0}} : MIN_INT;
    end

    // Remainder takes the dividend's sign; product and quotient take signA ^ signB
    assign new_neg = (is_div(funct3) && is_rem(funct3)) ? sign_a : (sign_a ^ sign_b);

    // Multiply step: multiplier sits in the low half and shifts out as the
    // partial product shifts in from the top.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: {remainder, dividend/quotient} shifts left one bit per cycle.
    logic [WIDTH:0]     div_trial;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_q};
    assign div_ok    = ~div_trial[WIDTH];
    assign div_next  = {div_ok ? div_trial[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1],
                        acc_q[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] fix_in, fix_out;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        fix_in = acc_q;
        if (is_div(f3_q))
            fix_in = {{WIDTH{1'b0}},
                      is_rem(f3_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0]};
    end

    muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix (
        .val_i (fix_in),
        .neg_i (neg_q),
        .res_o (fix_out)
    );

    assign final_res = ((f3_q == F3_MUL) || is_div(f3_q)) ? fix_out[WIDTH-1:0]
                                                          : fix_out[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_b_d  = mag_b_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (Flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        f3_d    = funct3;
                        neg_d   = new_neg;
                        cnt_d   = {CNT_W{1'b0}};
                        mag_b_d = mag_b;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        if (special) begin
                            state_d  = ST_DONE;
                            result_d = special_res;
                        end else begin
                            state_d  = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // One extra cycle after the last iteration applies the sign
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        result_d = final_res;
                        state_d  = ST_DONE;
                    end else begin
                        acc_d = is_div(f3_q) ? div_next : mul_next;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            mag_b_q  <= {WIDTH{1'b0}};
            f3_q     <= 3'b000;
            neg_q    <= 1'b0;
            result_q <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_b_q  <= mag_b_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign Busy        = (state_q == ST_RUN);
    assign Done        = (state_q == ST_DONE);
    assign Result      = result_q;
    assign dbg_state_o = state_q;

endmodule
